// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word reads
// over a req/gnt/rvalid handshake and feeds decode through the IF/ID register.
// A one-entry skid buffer absorbs a returning word while decode is stalled.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   skid_instr;
  logic [XLEN-1:0]   skid_pc;
  logic              drop;
  logic [XLEN-1:0]   pc_next4;
  logic [XLEN-1:0]   redirect_target;

  assign pc_next4        = pc_q + XLEN'(4);
  assign redirect_target = redirect_pc & ~XLEN'(3);

  // Address always tracks the PC; a request is only presented in FETCH and never during reset.
  assign imem_addr = pc_q;
  assign imem_req  = reset_n & (state == S_FETCH);

  // Fetch FSM, PC, skid buffer and IF/ID register; redirect takes priority over everything.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_FETCH;
      pc_q           <= RESET_PC;
      drop           <= 1'b0;
      skid_instr     <= '0;
      skid_pc        <= '0;
      if_valid       <= 1'b0;
      if_instruction <= '0;
      if_pc          <= '0;
      if_pc_plus4    <= '0;
    end else begin
      // Decode consumes the current entry; a load below may refill it on the same edge.
      if (if_valid && !stall) begin
        if_valid <= 1'b0;
      end

      if (redirect_valid) begin
        pc_q       <= redirect_target;
        if_valid   <= 1'b0;
        skid_instr <= '0;
        skid_pc    <= '0;
        case (state)
          S_FETCH: begin
            if (imem_gnt) begin
              state <= S_WAIT;
              drop  <= 1'b1;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              state <= S_FETCH;
              drop  <= 1'b0;
            end else begin
              drop <= 1'b1;
            end
          end
          default: state <= S_FETCH;
        endcase
      end else begin
        case (state)
          S_FETCH: begin
            if (imem_gnt) begin
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              if (drop) begin
                drop  <= 1'b0;
                state <= S_FETCH;
              end else if (!if_valid || !stall) begin
                if_valid       <= 1'b1;
                if_instruction <= imem_rdata;
                if_pc          <= pc_q;
                if_pc_plus4    <= pc_next4;
                pc_q           <= pc_next4;
                state          <= S_FETCH;
              end else begin
                skid_instr <= imem_rdata;
                skid_pc    <= pc_q;
                pc_q       <= pc_next4;
                state      <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (!stall) begin
              if_valid       <= 1'b1;
              if_instruction <= skid_instr;
              if_pc          <= skid_pc;
              if_pc_plus4    <= skid_pc + XLEN'(4);
              state          <= S_FETCH;
            end
          end
          default: state <= S_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios followed by random
// stall/grant/latency/redirect traffic, checked every cycle against a
// queue-based model of the IF/ID + skid contents and the fetch address stream.
module tb_instruction_fetch_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid;
  logic [31:0] if_instruction, if_pc, if_pc_plus4;

  logic        w_stall, w_redirect_valid, w_imem_req, w_imem_gnt, w_imem_rvalid, w_if_valid;
  logic [31:0] w_redirect_pc, w_imem_addr, w_imem_rdata, w_if_instruction, w_if_pc, w_if_pc_plus4;

  instruction_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instruction(if_instruction),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clock(clock), .reset_n(reset_n), .stall(w_stall),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(w_imem_gnt),
    .imem_rvalid(w_imem_rvalid), .imem_rdata(w_imem_rdata),
    .if_valid(w_if_valid), .if_instruction(w_if_instruction),
    .if_pc(w_if_pc), .if_pc_plus4(w_if_pc_plus4)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] q_pc[$];     // pcs of words held for decode, oldest first (max 2)
  bit          pend;        // a granted read is awaiting rvalid
  bit          pend_drop;   // that read was overtaken by a redirect
  int          lat;         // cycles still to wait before rvalid
  int          lat_fix;     // fixed latency for directed steps, -1 = random
  logic [31:0] pend_addr;
  logic [31:0] exp_fetch;   // next address the stage should request
  int          retired;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h2009_0003;
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic bit exp_req();
    return !pend && (q_pc.size() < 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_pc.delete();
    pend      = 1'b0;
    pend_drop = 1'b0;
    lat       = 0;
    exp_fetch = 32'h0;
  endtask

  task automatic check_model();
    chk("req", 32'(imem_req), 32'(exp_req()));
    if (exp_req()) chk("addr", imem_addr, exp_fetch);
    chk("if_valid", 32'(if_valid), 32'(q_pc.size() > 0));
    if (q_pc.size() > 0) begin
      chk("if_pc", if_pc, q_pc[0]);
      chk("if_instruction", if_instruction, word_at(q_pc[0]));
      chk("if_pc_plus4", if_pc_plus4, q_pc[0] + 32'd4);
    end
  endtask

  // One clock: check outputs, drive inputs, advance the model over the edge.
  task automatic tick(input bit st, input bit rd, input logic [31:0] rpc, input bit g);
    bit rv, hs, deliver, retire;
    logic [31:0] daddr;
    check_model();
    rv      = pend && (lat == 0);
    hs      = exp_req() && g;
    daddr   = pend_addr;
    deliver = 1'b0;
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_gnt       = g;
    imem_rvalid    = rv;
    imem_rdata     = rv ? word_at(pend_addr) : $urandom;
    @(posedge clock);
    if (rv) begin
      pend    = 1'b0;
      deliver = !pend_drop && !rd;
    end else if (pend) begin
      lat--;
      if (rd) pend_drop = 1'b1;
    end
    if (hs) begin
      pend      = 1'b1;
      pend_addr = exp_fetch;
      pend_drop = rd;
      lat       = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 2));
    end
    retire = (q_pc.size() > 0) && !st && !rd;
    if (rd) begin
      q_pc.delete();
    end else begin
      if (retire) begin
        void'(q_pc.pop_front());
        retired++;
      end
      if (deliver) q_pc.push_back(daddr);
    end
    if (rd) exp_fetch = rpc & ~32'd3;
    else if (hs) exp_fetch = exp_fetch + 32'd4;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_pc_plus4", if_pc_plus4, 32'h0);
    chk("rst_if_instruction", if_instruction, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    #1;
  endtask

  initial begin
    bit st, rd, g;
    logic [31:0] rpc;
    retired          = 0;
    lat_fix          = 0;
    w_stall          = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = 32'h0;
    w_imem_gnt       = 1'b0;
    w_imem_rvalid    = 1'b0;
    w_imem_rdata     = 32'h0;

    // Reset and release
    do_reset();
    chk("t1_req", 32'(imem_req), 32'h1);
    chk("t1_addr", imem_addr, 32'h0);

    // Wrap-around reset PC on the second instance
    chk("wrap_req", 32'(w_imem_req), 32'h1);
    chk("wrap_addr", w_imem_addr, 32'hFFFF_FFFC);
    w_imem_gnt = 1'b1;
    @(negedge clock);
    w_imem_gnt = 1'b0;
    chk("wrap_wait_req", 32'(w_imem_req), 32'h0);
    w_imem_rvalid = 1'b1;
    w_imem_rdata  = 32'hCAFE_F00D;
    @(negedge clock);
    w_imem_rvalid = 1'b0;
    chk("wrap_if_valid", 32'(w_if_valid), 32'h1);
    chk("wrap_if_pc", w_if_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", w_if_pc_plus4, 32'h0);
    chk("wrap_instr", w_if_instruction, 32'hCAFE_F00D);
    chk("wrap_next_addr", w_imem_addr, 32'h0);
    chk("wrap_next_req", 32'(w_imem_req), 32'h1);

    // Zero-wait memory, no stall: one instruction every two cycles
    tick(0, 0, 32'h0, 1);
    tick(0, 0, 32'h0, 0);
    chk("t2_pc0", if_pc, 32'h0);
    chk("t2_plus4_0", if_pc_plus4, 32'h4);
    tick(0, 0, 32'h0, 1);
    tick(0, 0, 32'h0, 0);
    chk("t2_pc1", if_pc, 32'h4);
    chk("t2_plus4_1", if_pc_plus4, 32'h8);

    // Return while stalled goes to the skid buffer
    tick(1, 0, 32'h0, 1);
    tick(1, 0, 32'h0, 0);
    chk("t3_hold_req", 32'(imem_req), 32'h0);
    chk("t3_hold_pc", if_pc, 32'h4);
    tick(1, 0, 32'h0, 0);
    tick(0, 0, 32'h0, 0);
    chk("t3_skid_pc", if_pc, 32'h8);
    chk("t3_next_addr", imem_addr, 32'hC);

    // Redirect while a read is in flight drops the returning word
    lat_fix = 2;
    tick(0, 0, 32'h0, 1);
    tick(0, 1, 32'h40, 0);
    tick(0, 0, 32'h0, 0);
    tick(0, 0, 32'h0, 0);
    chk("t4_req", 32'(imem_req), 32'h1);
    chk("t4_addr", imem_addr, 32'h40);
    chk("t4_if_valid", 32'(if_valid), 32'h0);

    // Redirect, rvalid and stall on the same edge
    lat_fix = 0;
    tick(0, 0, 32'h0, 1);
    tick(1, 1, 32'h40, 0);
    chk("t5_if_valid", 32'(if_valid), 32'h0);
    chk("t5_req", 32'(imem_req), 32'h1);
    chk("t5_addr", imem_addr, 32'h40);

    // Random traffic with a reset in the middle
    lat_fix = -1;
    retired = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      g   = 1'($urandom_range(0, 1));
      st  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 39) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      tick(st, rd, rpc, g);
    end
    check_model();
    chk("progress", 32'(retired >= 100), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
